// File: rtl/riscv_pkg.sv
// Shared encodings for the instruction loader: format codes, NOP word, FSM states
// and the immediate-range helper used by the packer.
package riscv_pkg;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_B = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // True when every bit selected by mask is a copy of the same value (sign extension holds).
  function automatic logic upper_uniform(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == 32'h0000_0000) || ((v & mask) == mask);
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational RISC-V word builder: places fields and immediate bits for one
// format and flags whether the immediate is exactly representable.
module imm_packer
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  // Bit placement and representability per instruction format.
  always_comb begin
    word_o  = {25'd0, opcode_i};
    legal_o = 1'b0;
    case (fmt_i)
      FMT_I: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = upper_uniform(imm_i, 32'hFFFF_F800);
      end
      FMT_S: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal_o = upper_uniform(imm_i, 32'hFFFF_F800);
      end
      FMT_B: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
        legal_o = upper_uniform(imm_i, 32'hFFFF_F000) & ~imm_i[0];
      end
      FMT_J: begin
        word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        legal_o = upper_uniform(imm_i, 32'hFFF0_0000) & ~imm_i[0];
      end
      FMT_U: begin
        word_o  = {imm_i[31:12], rd_i, opcode_i};
        legal_o = (imm_i[11:0] == 12'd0);
      end
      default: begin
        word_o  = {25'd0, opcode_i};
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encode_loader.sv
// Streams encoded instructions into memory: one word in flight at a time, illegal
// entries replaced by NOP and counted.
module imm_encode_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  acc_rem_q, acc_rem_d;
  logic [CNT_W-1:0]  wr_rem_q, wr_rem_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [31:0]       packed_s;
  logic              legal_s;
  logic              accept_s;
  logic              wr_done_s;
  logic              funct7_unused;

  // funct7 belongs to R-type, which this loader never emits.
  assign funct7_unused = ^funct7;

  imm_packer u_packer (
    .fmt_i    (fmt),
    .opcode_i (opcode),
    .rd_i     (rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .funct3_i (funct3),
    .imm_i    (imm),
    .word_o   (packed_s),
    .legal_o  (legal_s)
  );

  assign in_ready  = (state_q == ST_RUN) && (acc_rem_q != {CNT_W{1'b0}}) && (!we_q || mem_ready);
  assign accept_s  = in_valid & in_ready;
  assign wr_done_s = we_q & mem_ready;

  // Next-state and datapath update for the load run.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    acc_rem_d = acc_rem_q;
    wr_rem_d  = wr_rem_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          acc_rem_d = count;
          wr_rem_d  = count;
          err_d     = {CNT_W{1'b0}};
          we_d      = 1'b0;
          state_d   = (count == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (wr_done_s) begin
          addr_d   = addr_q + ADDR_W'(3'd4);
          wr_rem_d = wr_rem_q - CNT_W'(1'b1);
          we_d     = 1'b0;
        end else begin
          addr_d = addr_q;
        end
        // A new word may land in the same cycle the previous one retires.
        if (accept_s) begin
          wdata_d   = legal_s ? packed_s : NOP_WORD;
          we_d      = 1'b1;
          acc_rem_d = acc_rem_q - CNT_W'(1'b1);
          if (!legal_s && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1'b1);
          end else begin
            err_d = err_q;
          end
        end else begin
          wdata_d = wdata_q;
        end
        if (wr_done_s && (wr_rem_q == CNT_W'(1'b1))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      acc_rem_q <= {CNT_W{1'b0}};
      wr_rem_q  <= {CNT_W{1'b0}};
      err_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      acc_rem_q <= acc_rem_d;
      wr_rem_q  <= wr_rem_d;
      err_q     <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Directed and random checks of imm_encode_loader against a range-based legality
// model and an immediate decoder.
module tb_imm_encode_loader;
  import riscv_pkg::*;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, mem_we, mem_ready, busy, done;
  logic [31:0] base_addr, mem_addr, mem_wdata, imm;
  logic [15:0] count, err_cnt;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;

  int total = 0;
  int bad = 0;
  ent_t        ents[$];
  logic [31:0] got_words[$];
  logic [31:0] got_addrs[$];

  imm_encode_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Legality from the numeric range each format can represent.
  function automatic bit legal_ref(input logic [2:0] f, input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    case (f)
      FMT_I, FMT_S: return (s >= -64'sd2048) && (s <= 64'sd2047);
      FMT_B:        return (s >= -64'sd4096) && (s <= 64'sd4095) && (s % 64'sd2 == 64'sd0);
      FMT_J:        return (s >= -64'sd1048576) && (s <= 64'sd1048575) && (s % 64'sd2 == 64'sd0);
      FMT_U:        return (v % 32'd4096) == 32'd0;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] w);
    case (f)
      FMT_I:   return {{20{w[31]}}, w[31:20]};
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      FMT_U:   return {w[31:12], 12'd0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic ent_t make(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                input logic [31:0] v);
    ent_t e;
    e.fmt = f; e.opc = o; e.rd = d; e.rs1 = s1; e.rs2 = s2; e.f3 = f3;
    e.f7 = 7'($urandom); e.imm = v;
    return e;
  endfunction

  function automatic ent_t gen_legal();
    int k;
    k = int'($urandom_range(0, 4));
    case (k)
      0, 2:    return make(3'(k), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                           32'(int'($urandom_range(0, 4095)) - 2048));
      1:       return make(FMT_B, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                           32'((int'($urandom_range(0, 4095)) - 2048) * 2));
      3:       return make(FMT_J, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                           32'((int'($urandom_range(0, 1048575)) - 524288) * 2));
      default: return make(FMT_U, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                           $urandom & 32'hFFFF_F000);
    endcase
  endfunction

  function automatic ent_t gen_any();
    logic [31:0] v;
    v = ($urandom_range(0, 1) == 0) ? $urandom : 32'(int'($urandom_range(0, 10000)) - 5000);
    return make(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), v);
  endfunction

  task automatic drive(input ent_t e);
    fmt = e.fmt; opcode = e.opc; rd = e.rd; rs1 = e.rs1; rs2 = e.rs2;
    funct3 = e.f3; funct7 = e.f7; imm = e.imm;
  endtask

  task automatic check_word(input ent_t e, input logic [31:0] w);
    if (!legal_ref(e.fmt, e.imm)) begin
      chk("nop_word", w, NOP_WORD);
    end else begin
      chk("opcode", 32'(w[6:0]), 32'(e.opc));
      if (e.fmt == FMT_I || e.fmt == FMT_J || e.fmt == FMT_U) chk("rd", 32'(w[11:7]), 32'(e.rd));
      if (e.fmt == FMT_I || e.fmt == FMT_S || e.fmt == FMT_B) begin
        chk("rs1", 32'(w[19:15]), 32'(e.rs1));
        chk("funct3", 32'(w[14:12]), 32'(e.f3));
      end
      if (e.fmt == FMT_S || e.fmt == FMT_B) chk("rs2", 32'(w[24:20]), 32'(e.rs2));
      chk("imm_roundtrip", decode_imm(e.fmt, w), e.imm);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (i < got_words.size()) ? got_words[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    return (i < got_addrs.size()) ? got_addrs[i] : 32'hDEAD_BEEF;
  endfunction

  // One full load run of ents[0..n-1]; called and returns on a falling edge.
  task automatic run(input logic [31:0] base, input int n, input int stall_first,
                     input int rdy_pct, input int vld_pct);
    int fed, wrote, errs, stall_left, cyc, budget;
    bit pend, stalled, wr_now, acc_now, exp_rdy;
    logic [31:0] exp_addr, held_addr, held_data;
    got_words.delete(); got_addrs.delete();
    start = 1'b1; base_addr = base; count = 16'(n);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk1("zero_done", done, 1'b1);
      chk1("zero_we", mem_we, 1'b0);
      chk1("zero_busy", busy, 1'b0);
      @(negedge clk);
      chk1("zero_done_pulse", done, 1'b0);
      chk1("zero_we_after", mem_we, 1'b0);
      return;
    end
    chk1("run_busy", busy, 1'b1);
    chk("run_err_clear", 32'(err_cnt), 32'd0);
    fed = 0; wrote = 0; errs = 0; pend = 1'b0; stalled = 1'b0;
    stall_left = stall_first; cyc = 0; budget = n * 20 + 100;
    exp_addr = base; held_addr = 32'd0; held_data = 32'd0;
    while (wrote < n && cyc < budget) begin
      chk1("mem_we", mem_we, pend);
      if (pend) begin
        chk("mem_addr", mem_addr, exp_addr);
        check_word(ents[wrote], mem_wdata);
        if (stalled) begin
          chk("hold_addr", mem_addr, held_addr);
          chk("hold_data", mem_wdata, held_data);
        end
        held_addr = mem_addr; held_data = mem_wdata;
      end
      if (pend && stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      end
      if (fed < n && int'($urandom_range(0, 99)) < vld_pct) begin
        drive(ents[fed]); in_valid = 1'b1;
      end else begin
        drive(gen_any()); in_valid = 1'b0;
      end
      #1;
      exp_rdy = (fed < n) && (!pend || mem_ready);
      chk1("in_ready", in_ready, exp_rdy);
      wr_now  = pend && mem_ready;
      acc_now = in_valid && exp_rdy;
      stalled = pend && !mem_ready;
      if (wr_now) begin
        got_words.push_back(mem_wdata); got_addrs.push_back(mem_addr);
        wrote++; exp_addr = exp_addr + 32'd4; pend = 1'b0;
      end
      if (acc_now) begin
        if (!legal_ref(ents[fed].fmt, ents[fed].imm)) errs++;
        fed++; pend = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; mem_ready = 1'b0;
    chk("writes_complete", 32'(wrote), 32'(n));
    chk1("end_done", done, 1'b1);
    chk1("end_busy", busy, 1'b0);
    chk1("end_we", mem_we, 1'b0);
    chk("end_err_cnt", 32'(err_cnt), 32'(errs));
    @(negedge clk);
    chk1("done_pulse", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    base_addr = 32'd0; count = 16'd0;
    drive(make(FMT_I, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0));
    repeat (3) @(negedge clk);
    chk1("rst_we", mem_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // addi x1, x0, -1
    ents = {make(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF)};
    run(32'h100, 1, 0, 100, 100);
    chk("addi_word", word_at(0), 32'hFFF0_0093);
    chk("addi_addr", addr_at(0), 32'h100);

    // B imm 0x800 is legal (bit 11 lands at [7]); B imm 3 is odd and illegal
    ents = {make(FMT_B, 7'h63, 5'd0, 5'd2, 5'd3, 3'd1, 32'h800),
            make(FMT_B, 7'h63, 5'd0, 5'd2, 5'd3, 3'd1, 32'd3)};
    run(32'h100, 2, 0, 100, 100);
    chk("b800_bit7", 32'(word_at(0) & 32'h80), 32'h80);
    chk("b800_bit31", 32'(word_at(0) & 32'h8000_0000), 32'd0);
    chk("b3_nop", word_at(1), NOP_WORD);

    // first write back-pressured five cycles
    ents = {gen_legal(), gen_legal(), gen_legal()};
    run(32'h100, 3, 5, 100, 100);
    chk("stall_addr0", addr_at(0), 32'h100);
    chk("stall_addr1", addr_at(1), 32'h104);
    chk("stall_addr2", addr_at(2), 32'h108);

    // address wrap
    ents = {gen_legal(), gen_legal()};
    run(32'hFFFF_FFFC, 2, 0, 100, 100);
    chk("wrap_addr0", addr_at(0), 32'hFFFF_FFFC);
    chk("wrap_addr1", addr_at(1), 32'h0);

    // reset in the middle of a run with a write pending
    ents = {make(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h1000)};
    start = 1'b1; base_addr = 32'h200; count = 16'd3;
    @(negedge clk);
    start = 1'b0; drive(ents[0]); in_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("pre_rst_we", mem_we, 1'b1);
    chk("pre_rst_err", 32'(err_cnt), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk1("mid_rst_we", mem_we, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk1("mid_rst_ready", in_ready, 1'b0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_data", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(32'h300, 0, 0, 100, 100);

    // range boundaries, illegal formats and random mixed entries
    ents = {make(FMT_I, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'd2047),
            make(FMT_I, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'hFFFF_F800),
            make(FMT_I, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'd2048),
            make(FMT_S, 7'h23, 5'd0, 5'd4, 5'd5, 3'd2, 32'hFFFF_F7FF),
            make(FMT_B, 7'h63, 5'd0, 5'd4, 5'd5, 3'd0, 32'd4094),
            make(FMT_B, 7'h63, 5'd0, 5'd4, 5'd5, 3'd0, 32'hFFFF_F000),
            make(FMT_B, 7'h63, 5'd0, 5'd4, 5'd5, 3'd0, 32'd4096),
            make(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h000F_FFFE),
            make(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0000),
            make(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000),
            make(FMT_U, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'hFFFF_F000),
            make(FMT_U, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'h0000_0800),
            make(3'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0),
            make(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0)};
    for (int i = 0; i < 286; i++) ents.push_back(gen_any());
    run(32'h1000, 300, 0, 60, 70);

    // long random run of legal entries
    ents.delete();
    for (int i = 0; i < 10000; i++) ents.push_back(gen_legal());
    run(32'h8000, 10000, 0, 75, 75);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encode_loader.md
IMM_ENCODE_LOADER -- requirements
Module: imm_encode_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of memory write address.
REQ-002 SHALL have parameter CNT_W, default 16, width of instruction count and error counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a load run; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  byte address of first word; sampled with start.
REQ-007 SHALL have port count  input  CNT_W  instructions in run; sampled with start.
REQ-008 SHALL have port in_valid  input  1  instruction fields valid.
REQ-009 SHALL have port in_ready  output  1  block accepts fields this cycle.
REQ-010 SHALL have port fmt  input  3  format: 000 I, 001 B, 010 S, 011 J, 100 U, others illegal.
REQ-011 SHALL have port opcode  input  7, rd  input  5, rs1  input  5, rs2  input  5, funct3  input  3, funct7  input  7  instruction fields.
REQ-012 SHALL have port imm  input  32  full-width immediate value to encode.
REQ-013 SHALL have port mem_we  output  1  word write valid.
REQ-014 SHALL have port mem_ready  input  1  memory takes the write this cycle.
REQ-015 SHALL have port mem_addr  output  ADDR_W  write byte address.
REQ-016 SHALL have port mem_wdata  output  32  encoded instruction.
REQ-017 SHALL have port busy  output  1  high in RUN.
REQ-018 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-019 SHALL have port err_cnt  output  CNT_W  illegal entries in current run.

Function
REQ-020 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when count writes have completed (mem_we & mem_ready); DONE -> IDLE unconditionally next cycle; done high only in DONE.
REQ-021 SHALL go IDLE -> DONE directly when start with count = 0.
REQ-022 SHALL clear err_cnt and load address and remaining-accept/remaining-write counters on start.
REQ-023 SHALL drive in_ready = RUN & accepts-remaining > 0 & (!mem_we | mem_ready).
REQ-024 SHALL register the encoded word on in_valid & in_ready; mem_we rises the next cycle (latency 1); mem_addr/mem_wdata SHALL be held stable while mem_we & !mem_ready.
REQ-025 SHALL advance mem_addr by 4 per completed write, wrapping modulo 2^ADDR_W.
REQ-026 SHALL encode: opcode at [6:0] always; I: [31:20]=imm[11:0], rs1, funct3, rd; S: [31:25]=imm[11:5], [11:7]=imm[4:0], rs2, rs1, funct3; B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11], rs2, rs1, funct3; J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd; U: [31:12]=imm[31:12], rd.
REQ-027 SHALL treat as legal: I/S if imm[31:11] all equal; B if imm[31:12] all equal and imm[0]=0; J if imm[31:20] all equal and imm[0]=0; U if imm[11:0]=0; other fmt never.
REQ-028 SHALL write NOP 32'h00000013 for an illegal entry and increment err_cnt, saturating at all-ones.
REQ-029 SHALL guarantee: for legal entries, decoding mem_wdata with the team immediate extender at the same fmt returns imm exactly.
REQ-030 SHALL ignore start outside IDLE and in_valid outside RUN; funct7 is not encoded by any listed format and is reserved.

Reset
REQ-031 SHALL on reset, at any time including mid-run, force IDLE, mem_we=0, busy=0, done=0, err_cnt=0, mem_addr=0, mem_wdata=0; in-flight write dropped.

Structure
REQ-032 SHALL place format codes, NOP constant and FSM state encoding in shared package riscv_pkg.
REQ-033 SHALL isolate bit placement and legality check in combinational sub-module imm_packer.

Verification
REQ-034 SHALL check: start base_addr=0x100 count=1, I addi rd=1 imm=-1 -> one write addr 0x100 data 0xFFF00093, done pulse, err_cnt=0.
REQ-035 SHALL check: B imm=0x800 opcode 0x63 -> [7]=1, [31]=0, legal; B imm=3 -> NOP written, err_cnt=1.
REQ-036 SHALL check: count=3, mem_ready low 5 cycles on first write -> in_ready low, data stable, addresses 0x100,0x104,0x108 in order.
REQ-037 SHALL check: base_addr=0xFFFFFFFC count=2 -> second write at 0x00000000.
REQ-038 SHALL check: reset asserted mid-run with mem_we high -> next cycle all outputs at reset values; count=0 start -> done next cycle, no write.
REQ-039 SHALL check: random legal fmt/imm 10k entries round-trip through extender equal imm.
